// File: rtl/xm_result_stage_if.sv
// Execute-to-memory result handshake bundle: upstream entry, flush, downstream entry.
// master drives entries in and consumes them out; slave is the result stage.
interface xm_result_stage_if #(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 5
);
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    data_result;
    logic [REG_ADDR-1:0] in_rd;
    logic                in_wren;
    logic [1:0]          in_exc_code;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_result;
    logic [REG_ADDR-1:0] out_rd;
    logic                out_wren;
    logic                out_exception;

    modport master (
        output flush, in_valid, data_result, in_rd, in_wren, in_exc_code, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_wren, out_exception
    );

    modport slave (
        input  flush, in_valid, data_result, in_rd, in_wren, in_exc_code, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_wren, out_exception
    );
endinterface

// File: rtl/xm_result_stage.sv
// Purpose: EX->MEM result register; overflow codes are rewritten into an rstatus write.
// Latency: 1 cycle. Backpressure: XM_SKID_EN gives a 2-deep skid with registered in_ready,
// otherwise 1 entry with in_ready = !out_valid | out_ready.
module xm_result_stage #(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 5,
    parameter int RSTATUS  = 30
) (
    input logic           clock,
    input logic           reset,
    xm_result_stage_if.slave bus
);

    typedef struct packed {
        logic [WIDTH-1:0]    result;
        logic [REG_ADDR-1:0] rd;
        logic                wren;
        logic                exception;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state_q, state_nxt;
    entry_t in_entry, main_q;
    logic   accept, pop, in_ready_int, main_ld_in;

    // Any overflow code replaces the entry with an rstatus write, even when wren was 0.
    always_comb begin
        in_entry = '{result: bus.data_result, rd: bus.in_rd, wren: bus.in_wren, exception: 1'b0};
        if (bus.in_exc_code != 2'b00) begin
            in_entry.result    = {{(WIDTH-2){1'b0}}, bus.in_exc_code};
            in_entry.rd        = REG_ADDR'(RSTATUS);
            in_entry.wren      = 1'b1;
            in_entry.exception = 1'b1;
        end
    end

    assign pop    = (state_q != EMPTY) & bus.out_ready;
    assign accept = bus.in_valid & in_ready_int;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= EMPTY;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        if (bus.flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (accept) state_nxt = ONE;
`ifdef XM_SKID_EN
                ONE: begin
                    if (accept && !pop)      state_nxt = TWO;
                    else if (pop && !accept) state_nxt = EMPTY;
                end
                TWO:     if (pop) state_nxt = ONE;
`else
                ONE:     if (pop && !accept) state_nxt = EMPTY;
`endif
                default: state_nxt = EMPTY;
            endcase
        end
    end

`ifdef XM_SKID_EN
    entry_t skid_q;
    logic   main_ld_skid, skid_ld, in_ready_q;

    always_comb begin
        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        if (!bus.flush) begin
            case (state_q)
                EMPTY:   main_ld_in = accept;
                ONE: begin
                    main_ld_in = accept & pop;
                    skid_ld    = accept & ~pop;
                end
                TWO:     main_ld_skid = pop;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)       skid_q <= '0;
        else if (skid_ld) skid_q <= in_entry;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) main_q <= '0;
        else if (main_ld_in)   main_q <= in_entry;
        else if (main_ld_skid) main_q <= skid_q;
    end

    // Registered so that in_ready has no path from out_ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) in_ready_q <= 1'b1;
        else        in_ready_q <= (state_nxt != TWO);
    end

    assign in_ready_int = in_ready_q;
`else
    always_comb begin
        main_ld_in = 1'b0;
        if (!bus.flush) main_ld_in = accept;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)          main_q <= '0;
        else if (main_ld_in) main_q <= in_entry;
    end

    assign in_ready_int = (state_q == EMPTY) | bus.out_ready;
`endif

    assign bus.in_ready      = in_ready_int;
    assign bus.out_valid     = (state_q != EMPTY);
    assign bus.out_result    = bus.out_valid ? main_q.result : '0;
    assign bus.out_rd        = bus.out_valid ? main_q.rd     : '0;
    assign bus.out_wren      = bus.out_valid & main_q.wren;
    assign bus.out_exception = bus.out_valid & main_q.exception;

endmodule

// File: tb/tb_xm_result_stage.sv
// Scoreboarded bench for xm_result_stage; skid-specific sequences follow XM_SKID_EN.
module tb_xm_result_stage;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    xm_result_stage_if #(.WIDTH(32), .REG_ADDR(5)) bus ();

    xm_result_stage #(.WIDTH(32), .REG_ADDR(5), .RSTATUS(30)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wren;
        logic        exc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   waits;

    function automatic exp_t mk(input logic [31:0] r, input logic [4:0] rd, input logic w, input logic x);
        exp_t e;
        e.res = r; e.rd = rd; e.wren = w; e.exc = x;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pop is checked against the oldest expected entry.
    always @(negedge clock) begin
        if (reset) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_output: got result 0x%08h rd %0d, expected no entry at %0t",
                             bus.out_result, bus.out_rd, $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_result", bus.out_result, mon_e.res);
                    chk("out_rd", 32'(bus.out_rd), 32'(mon_e.rd));
                    chk("out_wren", 32'(bus.out_wren), 32'(mon_e.wren));
                    chk("out_exception", 32'(bus.out_exception), 32'(mon_e.exc));
                end
            end else if (!bus.out_valid) begin
                chk("gated_result", bus.out_result, 32'h0);
                chk("gated_ctl", {25'b0, bus.out_rd, bus.out_wren, bus.out_exception}, 32'h0);
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [4:0] rd, input logic wr,
                        input logic [1:0] ec, input exp_t e, output int w);
        bus.data_result = d;
        bus.in_rd       = rd;
        bus.in_wren     = wr;
        bus.in_exc_code = ec;
        bus.in_valid    = 1'b1;
        w = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                sb.push_back(e);
                @(posedge clock);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clock);
            #1;
            w++;
        end
        n_checks++;
        n_fails++;
        $display("FAIL send_timeout: got no in_ready in 20 cycles, expected acceptance at %0t", $time);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got simulation still running, expected $finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.flush       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.data_result = '0;
        bus.in_rd       = '0;
        bus.in_wren     = 1'b0;
        bus.in_exc_code = 2'b00;
        bus.out_ready   = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_out_result", bus.out_result, 32'h0);
        chk("rst_ctl", {25'b0, bus.out_rd, bus.out_wren, bus.out_exception}, 32'h0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        bus.out_ready = 1'b1;

        // Back-to-back stream, one per cycle, 1-cycle latency.
        send(32'h0000_00F0, 5'd1, 1'b1, 2'b00, mk(32'h0000_00F0, 5'd1, 1'b1, 1'b0), waits);
        chk("stream0_wait", 32'(waits), 32'h0);
        chk("latency_valid", 32'(bus.out_valid), 32'h1);
        chk("latency_result", bus.out_result, 32'h0000_00F0);
        send(32'h0F0F_0F0F, 5'd2, 1'b1, 2'b00, mk(32'h0F0F_0F0F, 5'd2, 1'b1, 1'b0), waits);
        chk("stream1_wait", 32'(waits), 32'h0);
        send(32'hFFFF_0000, 5'd3, 1'b1, 2'b00, mk(32'hFFFF_0000, 5'd3, 1'b1, 1'b0), waits);
        chk("stream2_wait", 32'(waits), 32'h0);
        idle(2);

        // Overflow rewrites (including wren=0) and a clean pass-through.
        send(32'h8000_0000, 5'd7, 1'b1, 2'b11, mk(32'h0000_0003, 5'd30, 1'b1, 1'b1), waits);
        send(32'h7FFF_FFFF, 5'd4, 1'b0, 2'b01, mk(32'h0000_0001, 5'd30, 1'b1, 1'b1), waits);
        send(32'h1234_5678, 5'd9, 1'b1, 2'b10, mk(32'h0000_0002, 5'd30, 1'b1, 1'b1), waits);
        send(32'hDEAD_BEEF, 5'd0, 1'b0, 2'b00, mk(32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0), waits);
        idle(2);
        chk("drain_exc", 32'(sb.size()), 32'h0);

        // Downstream stall: capacity and ordering.
        bus.out_ready = 1'b0;
        send(32'hAAAA_0001, 5'd10, 1'b1, 2'b00, mk(32'hAAAA_0001, 5'd10, 1'b1, 1'b0), waits);
`ifdef XM_SKID_EN
        send(32'hBBBB_0002, 5'd11, 1'b1, 2'b00, mk(32'hBBBB_0002, 5'd11, 1'b1, 1'b0), waits);
        chk("skid_b_wait", 32'(waits), 32'h0);
        chk("full_in_ready", 32'(bus.in_ready), 32'h0);
        bus.data_result = 32'hCCCC_0003; bus.in_rd = 5'd12; bus.in_wren = 1'b1;
        bus.in_exc_code = 2'b00; bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("full_blocks_c", 32'(bus.in_ready), 32'h0);
        end
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        send(32'hCCCC_0003, 5'd12, 1'b1, 2'b00, mk(32'hCCCC_0003, 5'd12, 1'b1, 1'b0), waits);
`else
        bus.data_result = 32'hBBBB_0002; bus.in_rd = 5'd11; bus.in_wren = 1'b1;
        bus.in_exc_code = 2'b00; bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("full_blocks_b", 32'(bus.in_ready), 32'h0);
        end
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        send(32'hBBBB_0002, 5'd11, 1'b1, 2'b00, mk(32'hBBBB_0002, 5'd11, 1'b1, 1'b0), waits);
`endif
        idle(3);
        chk("drain_stall", 32'(sb.size()), 32'h0);

        // Flush while full, with a competing input that must be dropped.
        bus.out_ready = 1'b0;
        send(32'h1111_0001, 5'd13, 1'b1, 2'b00, mk(32'h1111_0001, 5'd13, 1'b1, 1'b0), waits);
`ifdef XM_SKID_EN
        send(32'h2222_0002, 5'd14, 1'b1, 2'b00, mk(32'h2222_0002, 5'd14, 1'b1, 1'b0), waits);
`endif
        bus.data_result = 32'h0BAD_0BAD; bus.in_rd = 5'd15; bus.in_wren = 1'b1;
        bus.in_exc_code = 2'b00; bus.in_valid = 1'b1; bus.flush = 1'b1;
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        chk("flush_out_valid", 32'(bus.out_valid), 32'h0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'h1);
        bus.out_ready = 1'b1;
        idle(4);

        // Held entry stays stable while stalled.
        bus.out_ready = 1'b0;
        send(32'h5A5A_A5A5, 5'd12, 1'b1, 2'b00, mk(32'h5A5A_A5A5, 5'd12, 1'b1, 1'b0), waits);
        repeat (5) begin
            @(negedge clock);
            chk("stable_valid", 32'(bus.out_valid), 32'h1);
            chk("stable_result", bus.out_result, 32'h5A5A_A5A5);
        end
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        idle(2);
        chk("drain_stable", 32'(sb.size()), 32'h0);

        // Asynchronous reset between edges while holding an entry.
        bus.out_ready = 1'b0;
        send(32'h3333_3333, 5'd5, 1'b1, 2'b00, mk(32'h3333_3333, 5'd5, 1'b1, 1'b0), waits);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("arst_out_result", bus.out_result, 32'h0);
        chk("arst_ctl", {25'b0, bus.out_rd, bus.out_wren, bus.out_exception}, 32'h0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'h1);
        sb.delete();
        @(posedge clock);
        #2;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        send(32'h4444_0004, 5'd6, 1'b1, 2'b00, mk(32'h4444_0004, 5'd6, 1'b1, 1'b0), waits);
        chk("post_rst_wait", 32'(waits), 32'h0);
        chk("post_rst_valid", 32'(bus.out_valid), 32'h1);
        chk("post_rst_result", bus.out_result, 32'h4444_0004);
        idle(2);
        chk("final_drain", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/xm_result_stage.md
# xm_result_stage

Execute-to-memory result stage for the MIPS pipeline. It consumes the 32-bit result selected from the ALU operation units (AND, OR, add/sub, shift) together with the destination register and write-enable. It converts arithmetic overflow into the rstatus ($30) write, and holds the entry for the memory stage under a valid/ready handshake. An optional skid buffer gives full throughput while `in_ready` stays a pure register output.

## Interface
- `WIDTH`, 32, datapath width.
- `REG_ADDR`, 5, register-address width.
- `RSTATUS`, 30, register index written on overflow.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash of all held entries.
- `in_valid`  in  1  execute stage presents an entry.
- `in_ready`  out  1  stage can accept the entry this cycle.
- `data_result`  in  WIDTH  ALU result.
- `in_rd`  in  REG_ADDR  destination register.
- `in_wren`  in  1  entry writes the register file.
- `in_exc_code`  in  2  00 none; 01 add, 10 addi, 11 sub overflow.
- `out_valid`  out  1  entry available to the memory stage.
- `out_ready`  in  1  memory stage consumes the entry this cycle.
- `out_result`  out  WIDTH  held result.
- `out_rd`  out  REG_ADDR  held destination.
- `out_wren`  out  1  held write-enable.
- `out_exception`  out  1  held entry is an overflow rewrite.

## Operation
- Accept occurs when `in_valid & in_ready`. Pop occurs when `out_valid & out_ready`.
- Capture rewrite on accept:
  - If `in_exc_code != 0`, store result = {30'b0, in_exc_code}, rd = `RSTATUS`, wren = 1, exception = 1.
  - Otherwise store the inputs unchanged, with exception = 0.
  - The rewrite applies even when `in_wren = 0`.
- Storage is a main register (drives the outputs) plus a skid register (present only with the macro).
- State machine (macro on):
  - EMPTY: accept -> ONE.
  - ONE:
    - accept & pop -> ONE, main <= input.
    - accept & !pop -> TWO, skid <= input.
    - pop & !accept -> EMPTY.
    - neither -> ONE.
  - TWO:
    - No accept is possible, because `in_ready` = 0.
    - pop -> ONE, main <= skid.
    - otherwise stay in TWO.
- `in_ready` is registered and equals (next state != TWO).
- Order is strictly FIFO. No entry is duplicated or lost except by `flush`.
- `flush` has priority over accept and pop in the same cycle:
  - Next state is EMPTY.
  - The input is dropped, even if `in_valid & in_ready`.
  - A pop in the same cycle still counts as consumed by the downstream stage.
- Data registers are don't-care while their valid bit is 0. `out_result`/`out_rd`/`out_wren`/`out_exception` are gated to 0 when `out_valid` = 0.

## Timing
- Reset (`reset` = 0, asynchronous):
  - Outputs: `out_valid` = 0, `out_result` = 0, `out_rd` = 0, `out_wren` = 0, `out_exception` = 0, `in_ready` = 1.
  - State is EMPTY.
- Reset asserted mid-operation discards all entries immediately.
- Deassertion is taken synchronously; the first accept can occur on the first clock edge after release.
- Latency is 1 cycle: an entry accepted at edge N is on the outputs after edge N.
- Throughput:
  - Macro on: 1 entry/cycle sustained with `out_ready` = 1.
  - Macro off: also 1 entry/cycle, but `in_ready` depends combinationally on `out_ready`.
- `out_valid` and the output data do not change while `out_valid & !out_ready`, except on flush or reset.
- After a flush, `in_ready` = 1 on the next cycle.

## Configuration
- `XM_SKID_EN` defined:
  - Skid register and TWO state are present.
  - `in_ready` is a flop, with no combinational path from `out_ready`.
  - Capacity is 2 entries.
- `XM_SKID_EN` undefined:
  - Single register, states EMPTY and ONE only.
  - `in_ready` = !out_valid | out_ready (combinational).
  - Capacity is 1 entry.
  - Reset and flush behaviour are unchanged.

## Test plan
- Reset, then stream results 0x0000_00F0, 0x0F0F_0F0F, 0xFFFF_0000 with `out_ready` = 1 -> each appears 1 cycle later in order; `out_exception` = 0.
- Accept with `in_exc_code` = 11, `in_rd` = 7, `data_result` = 0x8000_0000 -> `out_rd` = 30, `out_result` = 0x0000_0003, `out_wren` = 1, `out_exception` = 1.
- (`XM_SKID_EN`) hold `out_ready` = 0 and offer A then B -> both accepted; `in_ready` = 0 the cycle after B; C is not accepted. Release `out_ready` -> A, B, C delivered in order, nothing dropped.
- In state TWO, assert `flush` together with `in_valid` = 1 -> next cycle `out_valid` = 0, `in_ready` = 1, and the flushed input never appears.
- Assert `reset` low asynchronously between edges while `out_valid` = 1 -> all outputs go to their reset values before the next edge; after release the first entry has 1-cycle latency.
- Hold `out_ready` = 0 for 5 cycles with an entry held -> `out_valid` and `out_result` stay stable for all 5 cycles.
